// File: rtl/hls_deadlock_multi_monitor.sv
// Dataflow-region deadlock monitor with persistence filtering and cause capture.
// Optional DEADLOCK_MON_STICKY_EN holds block until reset or clear.
module hls_deadlock_multi_monitor #(
  parameter int N_AXIS    = 4,
  parameter int N_INST    = 2,
  parameter int THRESHOLD = 64,
  parameter int CNT_W     = 8,
  localparam int N_MAX = (N_AXIS > N_INST) ? N_AXIS : N_INST,
  localparam int IDX_W = (N_MAX > 2) ? $clog2(N_MAX) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  input  logic [N_INST-1:0] inst_block_sigs,
  input  logic              enable,
  input  logic              clear,
  output logic              block,
  output logic              block_pending,
  output logic              cause_is_inst,
  output logic [IDX_W-1:0]  first_idx,
  output logic [CNT_W-1:0]  block_count
);

  localparam int PC_W = $clog2(THRESHOLD + 1);
  localparam logic [PC_W-1:0] TH   = PC_W'(THRESHOLD);
  localparam logic [PC_W-1:0] TH_1 = PC_W'(THRESHOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_BLOCKED
  } state_e;

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pcnt_q, pcnt_d;
  logic              block_q, block_d;
  logic              pend_q, pend_d;
  logic              cinst_q, cinst_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              axis_stall, inst_stall, raw, enter;
  logic [IDX_W-1:0]  ax_idx, in_idx;

`ifdef DEADLOCK_MON_STICKY_EN
  logic              seen_q, seen_d;
`endif

  assign axis_stall = |axis_block_sigs;
  assign inst_stall = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
  assign raw        = enable & (axis_stall | inst_stall);

  // Downward scans so the lowest asserted index wins.
  always_comb begin
    ax_idx = '0;
    for (int i = N_AXIS - 1; i >= 0; i--)
      if (axis_block_sigs[i]) ax_idx = IDX_W'(i);
    in_idx = '0;
    for (int i = N_INST - 1; i >= 0; i--)
      if (inst_block_sigs[i]) in_idx = IDX_W'(i);
  end

  always_comb begin
    state_d = state_q;
    pcnt_d  = '0;
    block_d = 1'b0;
    pend_d  = 1'b0;
    cinst_d = cinst_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    enter   = 1'b0;
`ifdef DEADLOCK_MON_STICKY_EN
    seen_d  = seen_q;
`endif
    if (clear) begin
      state_d = S_IDLE;
      cinst_d = 1'b0;
      idx_d   = '0;
      cnt_d   = '0;
`ifdef DEADLOCK_MON_STICKY_EN
      seen_d  = 1'b0;
`endif
    end else if (!enable) begin
      state_d = S_IDLE;
    end else begin
      if (raw) pcnt_d = (pcnt_q < TH) ? pcnt_q + 1'b1 : pcnt_q;
      unique case (state_q)
        S_IDLE:
          if (raw) state_d = (THRESHOLD == 1) ? S_BLOCKED : S_ARMED;
        S_ARMED:
          if (!raw) state_d = S_IDLE;
          else if (pcnt_q == TH_1) state_d = S_BLOCKED;
        S_BLOCKED:
          if (!raw) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      enter   = (state_d == S_BLOCKED) && (state_q != S_BLOCKED);
      pend_d  = (state_d == S_ARMED);
      block_d = (state_d == S_BLOCKED);
      if (enter) begin
        cinst_d = !axis_stall;
        idx_d   = axis_stall ? ax_idx : in_idx;
      end
`ifdef DEADLOCK_MON_STICKY_EN
      if (enter && !seen_q && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      seen_d = seen_q | enter;
`else
      if (enter && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
`endif
    end
`ifdef DEADLOCK_MON_STICKY_EN
    block_d = seen_d;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pcnt_q  <= '0;
      block_q <= 1'b0;
      pend_q  <= 1'b0;
      cinst_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
`ifdef DEADLOCK_MON_STICKY_EN
      seen_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      block_q <= block_d;
      pend_q  <= pend_d;
      cinst_q <= cinst_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef DEADLOCK_MON_STICKY_EN
      seen_q  <= seen_d;
`endif
    end
  end

  assign block         = block_q;
  assign block_pending = pend_q;
  assign cause_is_inst = cinst_q;
  assign first_idx     = idx_q;
  assign block_count   = cnt_q;

endmodule

// File: tb/tb_hls_deadlock_multi_monitor.sv
// Scoreboard bench for hls_deadlock_multi_monitor (THRESHOLD=4, CNT_W=2).
// Model tracks the consecutive-stall run length rather than an FSM.
module tb_hls_deadlock_multi_monitor;

  localparam int TH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] axis;
  logic [1:0] idle, blk;
  logic       en, clr;
  logic       block, pending, cinst;
  logic [1:0] idx;
  logic [1:0] cnt;

  typedef struct packed {
    logic       block;
    logic       pending;
    logic       cinst;
    logic [1:0] idx;
    logic [1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   run = 0;
  logic m_cinst = 0;
  int   m_idx = 0;
  int   m_cnt = 0;
  logic m_seen = 0;

  hls_deadlock_multi_monitor #(
    .N_AXIS(4), .N_INST(2), .THRESHOLD(TH), .CNT_W(2)
  ) dut (
    .clock(clk), .reset(reset),
    .axis_block_sigs(axis),
    .inst_idle_sigs(idle),
    .inst_block_sigs(blk),
    .enable(en), .clear(clr),
    .block(block), .block_pending(pending),
    .cause_is_inst(cinst), .first_idx(idx),
    .block_count(cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic drive(input logic [3:0] a, input logic [1:0] id,
                       input logic [1:0] b, input logic e, input logic c);
    exp_t x;
    logic ax_st, in_st, r;
    @(negedge clk);
    axis = a; idle = id; blk = b; en = e; clr = c;
    ax_st = |a;
    in_st = (&(id | b)) && (|b);
    r = e && (ax_st || in_st);
    if (c) begin
      run = 0; m_cinst = 0; m_idx = 0; m_cnt = 0; m_seen = 0;
    end else if (!e || !r) begin
      run = 0;
    end else begin
      run++;
      if (run == TH) begin
        m_cinst = !ax_st;
        m_idx = ax_st ? lowest(a) : lowest({2'b00, b});
`ifdef DEADLOCK_MON_STICKY_EN
        if (!m_seen && m_cnt < 3) m_cnt++;
        m_seen = 1;
`else
        if (m_cnt < 3) m_cnt++;
`endif
      end
    end
`ifdef DEADLOCK_MON_STICKY_EN
    x.block = m_seen;
`else
    x.block = (run >= TH);
`endif
    x.pending = (run >= 1) && (run < TH);
    x.cinst = m_cinst;
    x.idx = 2'(m_idx);
    x.cnt = 2'(m_cnt);
    exp_q.push_back(x);
  endtask

  task automatic ax(input logic [3:0] a, input int n);
    for (int i = 0; i < n; i++) drive(a, 2'b00, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("block", int'(block), int'(e.block));
        check("block_pending", int'(pending), int'(e.pending));
        check("cause_is_inst", int'(cinst), int'(e.cinst));
        check("first_idx", int'(idx), int'(e.idx));
        check("block_count", int'(cnt), int'(e.cnt));
      end
    end
  end

  initial begin
    reset = 1'b1;
    axis = '0; idle = '0; blk = '0; en = 1'b1; clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_block", int'(block), 0);
    check("rst_pending", int'(pending), 0);
    check("rst_cause", int'(cinst), 0);
    check("rst_idx", int'(idx), 0);
    check("rst_count", int'(cnt), 0);
    @(negedge clk);
    reset = 1'b0;

    // persistence then drop
    ax(4'b0100, 6);
    ax(4'b0000, 2);
    // glitch filter
    ax(4'b0001, 3);
    ax(4'b0000, 1);
    ax(4'b0001, 3);
    ax(4'b0000, 2);
    // instance stall, then non-stall pattern
    repeat (5) drive(4'b0, 2'b01, 2'b10, 1'b1, 1'b0);
    ax(4'b0000, 1);
    repeat (5) drive(4'b0, 2'b00, 2'b10, 1'b1, 1'b0);
    ax(4'b0000, 1);
    // clear while blocked, event on same cycle discarded
    ax(4'b1000, 5);
    drive(4'b1000, 2'b00, 2'b00, 1'b1, 1'b1);
    ax(4'b0000, 1);
    // enable low during armed
    ax(4'b0010, 2);
    drive(4'b0010, 2'b00, 2'b00, 1'b0, 1'b0);
    ax(4'b0010, 5);
    ax(4'b0000, 1);
    // saturation
    drive(4'b0, 2'b00, 2'b00, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      ax(4'b0001 << (k % 4), 4);
      ax(4'b0000, 1);
    end
    // randomized with held patterns
    begin
      logic [3:0] a;
      logic [1:0] id, b;
      a = '0; id = '0; b = '0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 5) == 0) begin
          a  = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0;
          id = 2'($urandom);
          b  = 2'($urandom);
        end
        drive(a, id, b,
              $urandom_range(0, 31) != 0,
              $urandom_range(0, 99) == 0);
      end
    end
    ax(4'b0000, 2);

    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
